// File: rtl/button_press_classifier.sv
// Debounces button edge pulses and classifies presses into short, long and
// double events with one FSM and a shared saturating cycle counter.
module button_press_classifier #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500_000,
  parameter int unsigned LONG_PRESS_CYCLES = 100_000_000,
  parameter int unsigned DOUBLE_GAP_CYCLES = 30_000_000,
  parameter int unsigned CNT_W             = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic rise_in,
  input  logic fall_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic pressed,
  output logic busy
);

  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TH  = CNT_W'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_dbCnt;
  logic             r_short;
  logic             r_long;
  logic             r_double;

  logic w_dbReady;
  logic w_rise;
  logic w_fall;
  logic w_accept;
  logic w_short;
  logic w_long;
  logic w_double;

  // A simultaneous rise and fall is a glitch: neither edge is usable.
  assign w_dbReady = (r_dbCnt == DB_MAX);
  assign w_rise    = enable & w_dbReady & rise_in & ~fall_in;
  assign w_fall    = enable & w_dbReady & fall_in & ~rise_in;

  // Edges are checked before timeouts so an edge wins a same-cycle collision.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_double    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_nextState = PRESSED;
          w_accept    = 1'b1;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_nextState = WAIT_GAP;
          w_accept    = 1'b1;
        end else if (r_cnt == LONG_TH) begin
          w_nextState = LONG_HELD;
          w_long      = 1'b1;
        end
      end
      LONG_HELD: begin
        if (w_fall) begin
          w_nextState = IDLE;
          w_accept    = 1'b1;
        end
      end
      WAIT_GAP: begin
        if (w_rise) begin
          w_nextState = SECOND;
          w_accept    = 1'b1;
        end else if (r_cnt == GAP_TH) begin
          w_nextState = IDLE;
          w_short     = 1'b1;
        end
      end
      SECOND: begin
        if (w_fall) begin
          w_nextState = IDLE;
          w_accept    = 1'b1;
          w_double    = 1'b1;
        end else if (r_cnt == LONG_TH) begin
          w_nextState = LONG_HELD;
          w_double    = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (!enable) begin
      w_nextState = IDLE;
      w_short     = 1'b0;
      w_long      = 1'b0;
      w_double    = 1'b0;
    end
  end

  // The debounce counter keeps running while disabled; only accepted edges clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dbCnt  <= DB_MAX;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      if (!enable || (w_nextState != r_state)) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_dbCnt <= '0;
      end else if (r_dbCnt != DB_MAX) begin
        r_dbCnt <= r_dbCnt + CNT_W'(1);
      end
    end
  end

  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_press = r_double;
  assign pressed      = (r_state == PRESSED) || (r_state == LONG_HELD) || (r_state == SECOND);
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_button_press_classifier.sv
// Drives directed and random button edges into button_press_classifier and
// compares every output each cycle with a timestamp-based reference model.
module tb_button_press_classifier;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int GAP  = 10;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic riseIn;
  logic fallIn;
  logic shortPress;
  logic longPress;
  logic doublePress;
  logic pressedOut;
  logic busyOut;

  always #5 clk = ~clk;

  button_press_classifier #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .DOUBLE_GAP_CYCLES(GAP),
    .CNT_W            (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rise_in     (riseIn),
    .fall_in     (fallIn),
    .short_press (shortPress),
    .long_press  (longPress),
    .double_press(doublePress),
    .pressed     (pressedOut),
    .busy        (busyOut)
  );

  // Model phases are tracked by the edge number they were entered at, and the
  // debounce window by the edge number of the last accepted edge.
  typedef enum int {M_IDLE, M_DOWN, M_HELD, M_GAP, M_SECOND} phase_t;

  int     checks  = 0;
  int     errors  = 0;
  int     edgeNum = 0;
  phase_t phase   = M_IDLE;
  int     phaseStart = 0;
  int     lastAccept = -1000;
  logic   expShort  = 1'b0;
  logic   expLong   = 1'b0;
  logic   expDouble = 1'b0;

  task automatic goPhase(input phase_t p);
    phase      = p;
    phaseStart = edgeNum;
  endtask

  task automatic modelEdge();
    int  timeIn;
    bit  ready;
    expShort  = 1'b0;
    expLong   = 1'b0;
    expDouble = 1'b0;
    if (reset) begin
      goPhase(M_IDLE);
      lastAccept = -1000;
    end else if (!enable) begin
      goPhase(M_IDLE);
    end else begin
      ready  = (edgeNum - lastAccept > DEB) && !(riseIn && fallIn);
      timeIn = edgeNum - phaseStart;
      case (phase)
        M_IDLE:
          if (ready && riseIn) begin goPhase(M_DOWN); lastAccept = edgeNum; end
        M_DOWN:
          if (ready && fallIn) begin goPhase(M_GAP); lastAccept = edgeNum; end
          else if (timeIn == LONG) begin goPhase(M_HELD); expLong = 1'b1; end
        M_HELD:
          if (ready && fallIn) begin goPhase(M_IDLE); lastAccept = edgeNum; end
        M_GAP:
          if (ready && riseIn) begin goPhase(M_SECOND); lastAccept = edgeNum; end
          else if (timeIn == GAP) begin goPhase(M_IDLE); expShort = 1'b1; end
        M_SECOND:
          if (ready && fallIn) begin goPhase(M_IDLE); lastAccept = edgeNum; expDouble = 1'b1; end
          else if (timeIn == LONG) begin goPhase(M_HELD); expDouble = 1'b1; end
        default: goPhase(M_IDLE);
      endcase
    end
  endtask

  task automatic checkOutput();
    logic expPressed;
    logic expBusy;
    expPressed = (phase == M_DOWN) || (phase == M_HELD) || (phase == M_SECOND);
    expBusy    = (phase != M_IDLE);
    checks++;
    assert (shortPress === expShort) else begin
      errors++;
      $error("FAIL short_press edge=%0d got %b exp %b", edgeNum, shortPress, expShort);
    end
    checks++;
    assert (longPress === expLong) else begin
      errors++;
      $error("FAIL long_press edge=%0d got %b exp %b", edgeNum, longPress, expLong);
    end
    checks++;
    assert (doublePress === expDouble) else begin
      errors++;
      $error("FAIL double_press edge=%0d got %b exp %b", edgeNum, doublePress, expDouble);
    end
    checks++;
    assert (pressedOut === expPressed) else begin
      errors++;
      $error("FAIL pressed edge=%0d got %b exp %b", edgeNum, pressedOut, expPressed);
    end
    checks++;
    assert (busyOut === expBusy) else begin
      errors++;
      $error("FAIL busy edge=%0d got %b exp %b", edgeNum, busyOut, expBusy);
    end
    checks++;
    assert ((32'(shortPress) + 32'(longPress) + 32'(doublePress)) <= 1) else begin
      errors++;
      $error("FAIL one_event edge=%0d got %b%b%b exp at most one", edgeNum,
             shortPress, longPress, doublePress);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic en, input logic rst);
    riseIn = r;
    fallIn = f;
    enable = en;
    reset  = rst;
    @(posedge clk);
    edgeNum++;
    modelEdge();
    @(negedge clk);
    checkOutput();
    riseIn = 1'b0;
    fallIn = 1'b0;
  endtask

  task automatic idleFor(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int rate;
    int rnd;
    logic en;
    logic rst;
    riseIn = 1'b0;
    fallIn = 1'b0;
    enable = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    idleFor(5);

    $display("[TB] short press");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); idleFor(20);

    $display("[TB] long press");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(30);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); idleFor(10);

    $display("[TB] double press");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); idleFor(4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); idleFor(15);

    $display("[TB] bounce");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(17);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); idleFor(15);

    $display("[TB] glitch and enable");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0); idleFor(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); idleFor(40);

    $display("[TB] reset mid-press");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); idleFor(15);

    $display("[TB] pending short dropped by enable");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); idleFor(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0); idleFor(15);

    $display("[TB] edge/threshold collisions");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(19);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); idleFor(9);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); idleFor(25);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); idleFor(15);

    $display("[TB] random");
    rate = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 60 == 0) rate = ($urandom_range(0, 1) == 0) ? 3 : 25;
      rnd = int'($urandom_range(0, 99));
      en  = ($urandom_range(0, 199) != 0);
      rst = ($urandom_range(0, 499) == 0);
      if (rnd < rate)            applyStimulus(1'b1, 1'b0, en, rst);
      else if (rnd < 2 * rate)   applyStimulus(1'b0, 1'b1, en, rst);
      else if (rnd == 99)        applyStimulus(1'b1, 1'b1, en, rst);
      else                       applyStimulus(1'b0, 1'b0, en, rst);
    end
    idleFor(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
